// File: rtl/display_scan.sv
// Scan driver for a 4-digit common-anode hex display: walks the digits of a
// frame-latched 16-bit value, one slot every CLK_DIV clocks, with registered outputs.
module display_scan #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_pos,
  input  logic        blank_lz,
  input  logic        en,
  output logic [3:0]  nibble,
  output logic [3:0]  digit_n,
  output logic        dp_n,
  output logic        blank
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick;
  logic          load;
  logic [1:0]    idx;
  logic [1:0]    idx_nx;
  logic [15:0]   shd;
  logic [15:0]   shd_nx;
  logic [3:0]    dp_shd;
  logic [3:0]    dp_nx;
  logic          lz;
  logic          lit;
  logic [3:0]    nib_nx;
  logic [3:0]    dig_nx;
  logic          dpn_nx;

  // Outputs are computed from the state the next edge will hold, so a slot
  // change and its new outputs land on the same edge, while en and blank_lz
  // still take effect within one clock.
  always_comb begin
    tick   = (cnt == LAST);
    load   = tick && (idx == 2'd3);
    idx_nx = tick ? idx + 2'd1 : idx;
    shd_nx = load ? value : shd;
    dp_nx  = load ? dp_pos : dp_shd;

    lz = 1'b0;
    case (idx_nx)
      2'd1:    lz = (shd_nx[15:4]  == 12'd0);
      2'd2:    lz = (shd_nx[15:8]  == 8'd0);
      2'd3:    lz = (shd_nx[15:12] == 4'd0);
      default: lz = 1'b0;
    endcase
    lz  = lz & blank_lz;
    lit = en & ~lz;

    nib_nx = shd_nx[{idx_nx, 2'b00} +: 4];
    dig_nx = lit ? ~(4'b0001 << idx_nx) : 4'b1111;
    dpn_nx = lit ? ~dp_nx[idx_nx] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= 2'd0;
      shd     <= 16'd0;
      dp_shd  <= 4'd0;
      nibble  <= 4'd0;
      digit_n <= 4'b1110;
      dp_n    <= 1'b1;
      blank   <= 1'b0;
    end else begin
      cnt     <= tick ? '0 : cnt + CW'(1);
      idx     <= idx_nx;
      shd     <= shd_nx;
      dp_shd  <= dp_nx;
      nibble  <= nib_nx;
      digit_n <= dig_nx;
      dp_n    <= dpn_nx;
      blank   <= ~lit;
    end
  end

endmodule
